spi_slave_ctrl: RTL and testbench
=================================

// Module: spi_slave_ctrl
// PURPOSE
//  Parametrised SPI slave: next generation of our fixed 8-bit, mode-0 slave. Adds width N, all four
//  SPI modes, MSB/LSB order, multi-word frames per CS assertion, a TX holding register with a
//  valid/ready handshake, and RX, underrun and abort flags. Sits between the external SPI pins and a
//  register/FIFO client. Everything runs on clk; SCK/MOSI/CS are treated as asynchronous.
// PARAMETERS
//  N          8       word width in bits, N>=2
//  CPOL       0       SCK idle level
//  CPHA       0       0: sample on leading edge, drive on trailing; 1: drive leading, sample trailing
//  LSB_FIRST  0       1: bit 0 goes first on both MOSI and MISO
//  TX_IDLE    '1      word sent when the TX holding register is empty at a word load
// PORTS
//  clk          in   1  system clock
//  reset        in   1  synchronous, active-high reset
//  SCK          in   1  SPI clock, async
//  MOSI         in   1  SPI data in, async
//  CS           in   1  chip select, active low, async
//  MISO         out  1  SPI data out
//  miso_oe      out  1  MISO output enable; 1 while the frame is active
//  tx_data      in   N  next word to transmit
//  tx_valid     in   1  tx_data valid
//  tx_ready     out  1  holding register empty; transfer happens when tx_valid&&tx_ready
//  rx_data      out  N  last received word; held until the next word completes
//  rx_valid     out  1  one-clk pulse: rx_data updated
//  tx_underrun  out  1  one-clk pulse: TX_IDLE loaded because the holding register was empty
//  frame_abort  out  1  one-clk pulse: CS rose mid-word
//  busy         out  1  frame active (synchronised CS low and frame start seen)
// BEHAVIOUR
//  - Sync: SCK, MOSI and CS each pass through 2 flops, then a 3rd SCK/CS stage for edge detect.
//    An edge is acted on 3 clk after the pin change. SCK high and low phases must each be >=4 clk.
//    Sync flops reset to SCK=CPOL, CS=1, MOSI=0.
//  - Leading edge = SCK rise if CPOL=0, fall if CPOL=1. Sample edge = leading if CPHA=0,
//    else trailing. Drive edge = the other one.
//  - FSM: IDLE -> ACTIVE on the synchronised CS falling edge. ACTIVE -> IDLE on the CS rising edge.
//    If CS is low when reset releases, stay in IDLE until CS goes high and then low again.
//  - Word load: takes the holding register (clears it, tx_ready=1 the next clk), or TX_IDLE plus
//    a tx_underrun pulse if it is empty.
//    CPHA=0: load on entry to ACTIVE and on the first drive edge after a word's last sample.
//    CPHA=1: load on the drive edge of bit 0 of each word.
//    The first bit appears on MISO in the clk after the load; later bits shift on drive edges.
//  - MISO is low in IDLE.
//  - tx_valid&&tx_ready in the same clk as a load: the load sees the old (empty) register, so
//    TX_IDLE goes out and the new word stays held for the next load.
//  - RX: shift the sampled MOSI into rx_shift (MSB-first or LSB-first per LSB_FIRST).
//    bit_cnt runs 0..N-1 and wraps to 0. On the sample edge with bit_cnt==N-1, rx_data takes the
//    full word and rx_valid pulses in the next clk. There is no backpressure: an unread rx_data is
//    overwritten.
//  - CS rising edge with bit_cnt!=0: pulse frame_abort, discard the partial word, bit_cnt=0, no
//    rx_valid. A held TX word stays held.
//  - SCK edges in IDLE are ignored.
//  - Reset (any time, including mid-frame): state=IDLE, bit_cnt=0, shift registers=0, holding
//    register empty.
//    Outputs: MISO=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0,
//    frame_abort=0, busy=0.
// TESTING
//  1. N=8, mode 0, hold 0x3C, master sends 0xA5 -> rx_data=0xA5 with one rx_valid pulse;
//     MISO sends 0,0,1,1,1,1,0,0.
//  2. Mode 3, hold 0x81 then 0x7E while CS stays low, master sends 0x12,0x34 -> two rx_valid
//     pulses (0x12, 0x34); MISO returns 0x81, 0x7E; no underrun.
//  3. Holding register empty at frame start -> MISO sends 0xFF, tx_underrun pulses once,
//     rx_data is still correct.
//  4. CS rises after 5 SCK bits -> frame_abort pulses, no rx_valid; the next full frame
//     0x5A gives rx_data=0x5A.
//  5. reset asserted mid-word, CS held low -> all outputs at reset values; no activity until
//     CS rises and falls again.
//  6. N=12, LSB_FIRST=1, mode 1, master sends 0xABC LSB-first -> rx_data=0xABC;
//     hold 0x123 appears on MISO LSB-first.

Source files
------------

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: N-bit SPI slave, all four modes, MSB/LSB order, TX holding register, RX/underrun/abort flags
module spi_slave_ctrl #(
    parameter int N = 8,
    parameter int CPOL = 0,
    parameter int CPHA = 0,
    parameter int LSB_FIRST = 0,
    parameter logic [N-1:0] TX_IDLE = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         SCK,
    input  logic         MOSI,
    input  logic         CS,
    output logic         MISO,
    output logic         miso_oe,
    input  logic [N-1:0] tx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    output logic [N-1:0] rx_data,
    output logic         rx_valid,
    output logic         tx_underrun,
    output logic         frame_abort,
    output logic         busy
);
    localparam int CW = $clog2(N);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [2:0] sck_q, sck_d, cs_q, cs_d, vld_q, vld_d;
    logic [1:0] mosi_q, mosi_d;
    logic [0:0] state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [N-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d, hold_q, hold_d, rx_data_q, rx_data_d;
    logic hold_full_q, hold_full_d, rx_valid_q, rx_valid_d, underrun_q, underrun_d, abort_q, abort_d;
    logic sck_rise, sck_fall, lead, trail, cs_fall, cs_rise, active, sample_e, drive_e, last_bit, load, accept;
    logic [N-1:0] rx_word, tx_shifted;

    always_comb begin
        sck_d = {sck_q[1:0], SCK};
        cs_d = {cs_q[1:0], CS};
        mosi_d = {mosi_q[0], MOSI};
        // vld_q[i] marks that cs_q[i] holds a real pin sample rather than its reset value
        vld_d = {vld_q[1:0], 1'b1};
        sck_rise = sck_q[1] & ~sck_q[2];
        sck_fall = ~sck_q[1] & sck_q[2];
        lead = CPOL != 0 ? sck_fall : sck_rise;
        trail = CPOL != 0 ? sck_rise : sck_fall;
        cs_fall = vld_q[2] & cs_q[2] & ~cs_q[1];
        cs_rise = cs_q[1] & ~cs_q[2];
        active = state_q == ACTIVE;
        sample_e = active & ~cs_rise & (CPHA != 0 ? trail : lead);
        drive_e = active & ~cs_rise & (CPHA != 0 ? lead : trail);
        last_bit = bit_cnt_q == CW'(N - 1);
        rx_word = LSB_FIRST != 0 ? {mosi_q[1], rx_shift_q[N-1:1]} : {rx_shift_q[N-2:0], mosi_q[1]};
        tx_shifted = LSB_FIRST != 0 ? {1'b0, tx_shift_q[N-1:1]} : {tx_shift_q[N-2:0], 1'b0};
        load = (~active & cs_fall & (CPHA == 0)) | (drive_e & (bit_cnt_q == '0));
        accept = tx_valid & ~hold_full_q;
        state_d = active ? (cs_rise ? IDLE : ACTIVE) : (cs_fall ? ACTIVE : IDLE);
        bit_cnt_d = (~active | cs_rise) ? '0 : sample_e ? (last_bit ? '0 : bit_cnt_q + 1'b1) : bit_cnt_q;
        rx_shift_d = (~active | cs_rise) ? '0 : sample_e ? rx_word : rx_shift_q;
        rx_data_d = sample_e & last_bit ? rx_word : rx_data_q;
        rx_valid_d = sample_e & last_bit;
        tx_shift_d = load ? (hold_full_q ? hold_q : TX_IDLE) : drive_e ? tx_shifted : tx_shift_q;
        underrun_d = load & ~hold_full_q;
        abort_d = active & cs_rise & (bit_cnt_q != '0);
        hold_full_d = accept | (hold_full_q & ~load);
        hold_d = accept ? tx_data : hold_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_q <= {3{CPOL != 0}};
            cs_q <= '1;
            mosi_q <= '0;
            vld_q <= '0;
            state_q <= IDLE;
            bit_cnt_q <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            hold_q <= '0;
            hold_full_q <= 1'b0;
            rx_data_q <= '0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            sck_q <= sck_d;
            cs_q <= cs_d;
            mosi_q <= mosi_d;
            vld_q <= vld_d;
            state_q <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            hold_q <= hold_d;
            hold_full_q <= hold_full_d;
            rx_data_q <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            underrun_q <= underrun_d;
            abort_q <= abort_d;
        end
    end

    assign MISO = active & (LSB_FIRST != 0 ? tx_shift_q[0] : tx_shift_q[N-1]);
    assign miso_oe = active;
    assign busy = active;
    assign tx_ready = ~hold_full_q;
    assign rx_data = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign frame_abort = abort_q;
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl: three slave configurations driven by a bench SPI master and checked against a word-level model
module tb_spi_slave_ctrl;
    localparam int H = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic sck [3];
    logic mosi [3];
    logic cs [3];
    logic txv [3];
    logic miso [3];
    logic oe [3];
    logic txr [3];
    logic rxv [3];
    logic und [3];
    logic abt [3];
    logic bsy [3];
    logic [7:0] td0, td1, rx0, rx1;
    logic [11:0] td2, rx2;

    spi_slave_ctrl #(.N(8)) u0 (
        .clk(clk), .reset(reset), .SCK(sck[0]), .MOSI(mosi[0]), .CS(cs[0]), .MISO(miso[0]),
        .miso_oe(oe[0]), .tx_data(td0), .tx_valid(txv[0]), .tx_ready(txr[0]), .rx_data(rx0),
        .rx_valid(rxv[0]), .tx_underrun(und[0]), .frame_abort(abt[0]), .busy(bsy[0])
    );
    spi_slave_ctrl #(.N(8), .CPOL(1), .CPHA(1)) u1 (
        .clk(clk), .reset(reset), .SCK(sck[1]), .MOSI(mosi[1]), .CS(cs[1]), .MISO(miso[1]),
        .miso_oe(oe[1]), .tx_data(td1), .tx_valid(txv[1]), .tx_ready(txr[1]), .rx_data(rx1),
        .rx_valid(rxv[1]), .tx_underrun(und[1]), .frame_abort(abt[1]), .busy(bsy[1])
    );
    spi_slave_ctrl #(.N(12), .CPHA(1), .LSB_FIRST(1)) u2 (
        .clk(clk), .reset(reset), .SCK(sck[2]), .MOSI(mosi[2]), .CS(cs[2]), .MISO(miso[2]),
        .miso_oe(oe[2]), .tx_data(td2), .tx_valid(txv[2]), .tx_ready(txr[2]), .rx_data(rx2),
        .rx_valid(rxv[2]), .tx_underrun(und[2]), .frame_abort(abt[2]), .busy(bsy[2])
    );

    int checks = 0;
    int failures = 0;
    bit hold_full [3];
    logic [11:0] hold_val [3];
    int und_exp [3];
    int und_got [3];
    int abt_exp [3];
    int abt_got [3];
    logic [13:0] exp_q [$];

    function automatic int nb(input int u);
        return u == 2 ? 12 : 8;
    endfunction
    function automatic bit cpol(input int u);
        return u == 1;
    endfunction
    function automatic bit cpha(input int u);
        return u != 0;
    endfunction
    function automatic bit lsb(input int u);
        return u == 2;
    endfunction
    function automatic logic [11:0] rxd(input int u);
        return u == 0 ? {4'h0, rx0} : u == 1 ? {4'h0, rx1} : rx2;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Word-level model of a load: take the held word, or the idle pattern with an underrun
    task automatic mload(input int u, output logic [11:0] w);
        if (hold_full[u]) begin
            w = hold_val[u];
            hold_full[u] = 1'b0;
        end else begin
            w = 12'hFFF >> (12 - nb(u));
            und_exp[u]++;
        end
    endtask

    task automatic push(input int u, input logic [11:0] v);
        chk("tx_ready_before_push", txr[u], 1);
        if (u == 0) td0 = v[7:0];
        else if (u == 1) td1 = v[7:0];
        else td2 = v;
        txv[u] = 1'b1;
        tick(1);
        txv[u] = 1'b0;
        hold_full[u] = 1'b1;
        hold_val[u] = v;
        chk("tx_ready_after_push", txr[u], 0);
    endtask

    task automatic frame(input int u, input logic [11:0] w0, input logic [11:0] w1, input int nw,
                         input int cut, input logic [11:0] mid, input bit do_mid,
                         output logic [11:0] g0, output logic [11:0] g1);
        logic [11:0] cur, got, w;
        int n, b, nbits;
        n = nb(u);
        g0 = '0;
        g1 = '0;
        cur = '0;
        cs[u] = 1'b0;
        tick(8);
        if (!cpha(u)) mload(u, cur);
        for (int k = 0; k < nw; k++) begin
            w = k == 0 ? w0 : w1;
            if (cpha(u)) mload(u, cur);
            nbits = (k == nw - 1 && cut > 0) ? cut : n;
            if (nbits == n) exp_q.push_back({2'(u), w});
            got = '0;
            for (int i = 0; i < nbits; i++) begin
                b = lsb(u) ? i : n - 1 - i;
                if (cpha(u)) sck[u] = ~cpol(u);
                mosi[u] = w[b];
                tick(H);
                got[b] = miso[u];
                chk("miso_bit", miso[u], cur[b]);
                sck[u] = cpha(u) ? cpol(u) : ~cpol(u);
                tick(H);
                if (!cpha(u)) sck[u] = cpol(u);
            end
            chk("busy_in_frame", bsy[u], 1);
            if (nbits == n && !cpha(u)) mload(u, cur);
            if (k == 0) g0 = got;
            else g1 = got;
            if (k == 0 && do_mid) push(u, mid);
        end
        tick(H);
        cs[u] = 1'b1;
        if (cut > 0) abt_exp[u]++;
        tick(10);
        chk("busy_after_frame", bsy[u], 0);
        chk("underrun_count", und_got[u], und_exp[u]);
        chk("abort_count", abt_got[u], abt_exp[u]);
        chk("tx_ready_model", txr[u], !hold_full[u]);
    endtask

    task automatic reset_vals(input int u);
        chk("rst_miso", miso[u], 0);
        chk("rst_oe", oe[u], 0);
        chk("rst_tx_ready", txr[u], 1);
        chk("rst_rx_data", rxd(u), 0);
        chk("rst_rx_valid", rxv[u], 0);
        chk("rst_underrun", und[u], 0);
        chk("rst_abort", abt[u], 0);
        chk("rst_busy", bsy[u], 0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int u = 0; u < 3; u++) begin
                logic [13:0] e;
                if (und[u]) und_got[u]++;
                if (abt[u]) abt_got[u]++;
                chk("oe_matches_busy", oe[u], bsy[u]);
                if (!bsy[u]) chk("miso_low_idle", miso[u], 0);
                if (rxv[u]) begin
                    e = exp_q.size() > 0 ? exp_q.pop_front() : 14'h3FFF;
                    chk("rx_word", {2'(u), rxd(u)}, e);
                end
            end
        end
    end

    initial begin
        logic [11:0] g0, g1, cur;
        for (int u = 0; u < 3; u++) begin
            sck[u] = cpol(u);
            mosi[u] = 1'b0;
            cs[u] = 1'b1;
            txv[u] = 1'b0;
            hold_full[u] = 1'b0;
            hold_val[u] = '0;
            und_exp[u] = 0;
            abt_exp[u] = 0;
        end
        td0 = '0;
        td1 = '0;
        td2 = '0;
        tick(4);
        for (int u = 0; u < 3; u++) reset_vals(u);
        reset = 1'b0;
        tick(6);

        push(0, 12'h3C);
        frame(0, 12'hA5, 12'h0, 1, 0, 12'h0, 1'b0, g0, g1);
        chk("t1_miso_word", g0, 12'h3C);
        chk("t1_rx_data", rx0, 8'hA5);

        push(1, 12'h81);
        frame(1, 12'h12, 12'h34, 2, 0, 12'h7E, 1'b1, g0, g1);
        chk("t2_miso_word0", g0, 12'h81);
        chk("t2_miso_word1", g1, 12'h7E);
        chk("t2_rx_data", rx1, 8'h34);
        chk("t2_no_underrun", und_got[1], 0);

        frame(1, 12'h5C, 12'h0, 1, 0, 12'h0, 1'b0, g0, g1);
        chk("t3_miso_idle_word", g0, 12'hFF);
        chk("t3_one_underrun", und_got[1], 1);
        chk("t3_rx_data", rx1, 8'h5C);

        frame(0, 12'hC3, 12'h0, 1, 5, 12'h0, 1'b0, g0, g1);
        chk("t4_abort_once", abt_got[0], 1);
        chk("t4_rx_kept", rx0, 8'hA5);
        frame(0, 12'h5A, 12'h0, 1, 0, 12'h0, 1'b0, g0, g1);
        chk("t4_rx_after_abort", rx0, 8'h5A);

        cs[0] = 1'b0;
        tick(8);
        mload(0, cur);
        for (int i = 0; i < 3; i++) begin
            mosi[0] = 1'b1;
            tick(H);
            sck[0] = 1'b1;
            tick(H);
            sck[0] = 1'b0;
        end
        tick(4);
        reset = 1'b1;
        tick(3);
        reset_vals(0);
        for (int u = 0; u < 3; u++) hold_full[u] = 1'b0;
        reset = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            mosi[0] = i[0];
            tick(H);
            sck[0] = 1'b1;
            tick(H);
            sck[0] = 1'b0;
        end
        tick(H);
        chk("t5_idle_after_reset", bsy[0], 0);
        cs[0] = 1'b1;
        tick(10);
        chk("t5_no_abort", abt_got[0], 1);
        chk("t5_underrun_count", und_got[0], und_exp[0]);
        push(0, 12'h99);
        frame(0, 12'h66, 12'h0, 1, 0, 12'h0, 1'b0, g0, g1);
        chk("t5_miso_word", g0, 12'h99);
        chk("t5_rx_data", rx0, 8'h66);

        push(2, 12'h123);
        frame(2, 12'hABC, 12'h0, 1, 0, 12'h0, 1'b0, g0, g1);
        chk("t6_miso_word", g0, 12'h123);
        chk("t6_rx_data", rx2, 12'hABC);

        tick(4);
        chk("rx_queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
